// File: rtl/riscv_v_wb_pipe.sv
// Vector EXE->MEM->WB write-back pipeline: registers ALU results and expands
// element size, vl and the v0 mask into per-byte register-file write enables.
module riscv_v_wb_pipe #(
    parameter int unsigned NUM_BYTES = 16,
    parameter int unsigned VL_W      = $clog2(NUM_BYTES) + 1,
    parameter int unsigned CNT_W     = 32,
    localparam int unsigned OSIZE_W  = $clog2(NUM_BYTES),
    localparam int unsigned IDX_W    = $clog2(NUM_BYTES),
    localparam int unsigned ADDR_W   = 5,
    localparam int unsigned DATA_W   = NUM_BYTES * 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               exe_valid,
    input  logic               exe_wr_en,
    input  logic [ADDR_W-1:0]  exe_rd_addr,
    input  logic [DATA_W-1:0]  exe_wr_data,
    input  logic [OSIZE_W-1:0] exe_osize_vector,
    input  logic [VL_W-1:0]    exe_vl,
    input  logic               exe_vm,
    input  logic [NUM_BYTES-1:0] exe_mask,
    input  logic               flush_exe,
    input  logic               stall_mem,
    output logic [NUM_BYTES-1:0] rf_wr_en_mem,
    output logic [ADDR_W-1:0]  rf_wr_addr_mem,
    output logic [DATA_W-1:0]  rf_wr_data_mem,
    output logic [NUM_BYTES-1:0] rf_wr_en_wb,
    output logic [ADDR_W-1:0]  rf_wr_addr_wb,
    output logic [DATA_W-1:0]  rf_wr_data_wb,
    output logic [CNT_W-1:0]   wb_retire_cnt
);

    logic [NUM_BYTES-1:0] exe_en;
    logic [NUM_BYTES-1:0] mem_en_q, wb_en_q, wb_en_d;
    logic [ADDR_W-1:0]    mem_addr_q, wb_addr_q;
    logic [DATA_W-1:0]    mem_data_q, wb_data_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 size_ok;
    int                   k;
    int                   elem;
    logic [IDX_W-1:0]     elem_idx;

    // Element size is taken from the lowest set bit of the one-hot-ish size vector.
    always_comb begin
        exe_en   = '0;
        size_ok  = 1'b0;
        k        = 0;
        elem     = 0;
        elem_idx = '0;
        for (int i = OSIZE_W - 1; i >= 0; i--) begin
            if (exe_osize_vector[i]) begin
                k       = i;
                size_ok = 1'b1;
            end
        end
        if (size_ok && exe_valid && exe_wr_en && !flush_exe) begin
            for (int b = 0; b < NUM_BYTES; b++) begin
                elem     = b >> k;
                elem_idx = IDX_W'(elem);
                exe_en[b] = (elem < int'(exe_vl)) && (exe_vm || exe_mask[elem_idx]);
            end
        end
    end

    // A stalled MEM stage sends a bubble into WB.
    always_comb begin
        wb_en_d = stall_mem ? '0 : mem_en_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_en_q   <= '0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            wb_en_q    <= '0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            cnt_q      <= '0;
        end else begin
            wb_en_q <= wb_en_d;
            if (!stall_mem) begin
                mem_en_q   <= exe_en;
                mem_addr_q <= exe_rd_addr;
                mem_data_q <= exe_wr_data;
                wb_addr_q  <= mem_addr_q;
                wb_data_q  <= mem_data_q;
            end
            if (wb_en_d != '0) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign rf_wr_en_mem   = mem_en_q;
    assign rf_wr_addr_mem = mem_addr_q;
    assign rf_wr_data_mem = mem_data_q;
    assign rf_wr_en_wb    = wb_en_q;
    assign rf_wr_addr_wb  = wb_addr_q;
    assign rf_wr_data_wb  = wb_data_q;
    assign wb_retire_cnt  = cnt_q;

endmodule

// File: tb/tb_riscv_v_wb_pipe.sv
// Directed bench for riscv_v_wb_pipe: a cycle model feeds a queue of expected
// MEM-stage results that is popped and compared after every clock.
module tb_riscv_v_wb_pipe;

    localparam int NB = 16;

    typedef struct packed {
        logic [NB-1:0]   en;
        logic [4:0]      addr;
        logic [NB*8-1:0] data;
    } stage_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            exe_valid = 1'b0, exe_wr_en = 1'b0, exe_vm = 1'b0;
    logic [4:0]      exe_rd_addr = '0;
    logic [127:0]    exe_wr_data = '0;
    logic [3:0]      exe_osize_vector = '0;
    logic [4:0]      exe_vl = '0;
    logic [NB-1:0]   exe_mask = '0;
    logic            flush_exe = 1'b0, stall_mem = 1'b0;
    logic [NB-1:0]   rf_wr_en_mem, rf_wr_en_wb;
    logic [4:0]      rf_wr_addr_mem, rf_wr_addr_wb;
    logic [127:0]    rf_wr_data_mem, rf_wr_data_wb;
    logic [31:0]     wb_retire_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    stage_t exp_q[$];
    stage_t m_mem, m_wb;
    logic [31:0] m_cnt;

    localparam logic [127:0] D1 = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [127:0] D2 = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    localparam logic [127:0] D3 = 128'h0F0E0D0C_0B0A0908_07060504_03020100;

    riscv_v_wb_pipe dut (
        .clk(clk), .rst_n(rst_n),
        .exe_valid(exe_valid), .exe_wr_en(exe_wr_en), .exe_rd_addr(exe_rd_addr),
        .exe_wr_data(exe_wr_data), .exe_osize_vector(exe_osize_vector), .exe_vl(exe_vl),
        .exe_vm(exe_vm), .exe_mask(exe_mask), .flush_exe(flush_exe), .stall_mem(stall_mem),
        .rf_wr_en_mem(rf_wr_en_mem), .rf_wr_addr_mem(rf_wr_addr_mem),
        .rf_wr_data_mem(rf_wr_data_mem), .rf_wr_en_wb(rf_wr_en_wb),
        .rf_wr_addr_wb(rf_wr_addr_wb), .rf_wr_data_wb(rf_wr_data_wb),
        .wb_retire_cnt(wb_retire_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference enables: element index by division, esize from the lowest size bit.
    function automatic logic [NB-1:0] ref_en(input logic v, input logic we, input logic fl,
                                             input logic [3:0] os, input logic [4:0] vl,
                                             input logic vm, input logic [NB-1:0] mask);
        logic [NB-1:0] r;
        int esize;
        r = '0;
        esize = 0;
        if (os[3]) esize = 8;
        if (os[2]) esize = 4;
        if (os[1]) esize = 2;
        if (os[0]) esize = 1;
        if (esize != 0 && v && we && !fl) begin
            for (int b = 0; b < NB; b++) begin
                if ((b / esize) < int'(vl) && (vm || mask[b / esize])) r[b] = 1'b1;
            end
        end
        return r;
    endfunction

    task automatic check_all(input string tag);
        stage_t e;
        if (exp_q.size() == 0) begin
            check({tag, " queue"}, 128'd1, 128'd0);
            return;
        end
        e = exp_q.pop_front();
        check({tag, " en_mem"},   rf_wr_en_mem,   e.en);
        check({tag, " addr_mem"}, rf_wr_addr_mem, e.addr);
        check({tag, " data_mem"}, rf_wr_data_mem, e.data);
        check({tag, " en_wb"},    rf_wr_en_wb,    m_wb.en);
        check({tag, " addr_wb"},  rf_wr_addr_wb,  m_wb.addr);
        check({tag, " data_wb"},  rf_wr_data_wb,  m_wb.data);
        check({tag, " cnt"},      wb_retire_cnt,  m_cnt);
    endtask

    task automatic step(input string tag, input logic v, input logic we, input logic [4:0] rd,
                        input logic [127:0] d, input logic [3:0] os, input logic [4:0] vl,
                        input logic vm, input logic [NB-1:0] mask, input logic fl,
                        input logic st);
        stage_t nxt;
        exe_valid = v; exe_wr_en = we; exe_rd_addr = rd; exe_wr_data = d;
        exe_osize_vector = os; exe_vl = vl; exe_vm = vm; exe_mask = mask;
        flush_exe = fl; stall_mem = st;
        if (st) begin
            m_wb.en = '0;
        end else begin
            nxt.en = ref_en(v, we, fl, os, vl, vm, mask);
            nxt.addr = rd;
            nxt.data = d;
            m_wb = m_mem;
            m_mem = nxt;
        end
        if (m_wb.en != '0) m_cnt = m_cnt + 1;
        exp_q.push_back(m_mem);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 1'b0, 5'd0, '0, 4'b0000, 5'd0, 1'b1, '0, 1'b0, 1'b0);
    endtask

    task automatic zero_outputs(input string tag);
        check({tag, " en_mem"},   rf_wr_en_mem,   '0);
        check({tag, " addr_mem"}, rf_wr_addr_mem, '0);
        check({tag, " data_mem"}, rf_wr_data_mem, '0);
        check({tag, " en_wb"},    rf_wr_en_wb,    '0);
        check({tag, " addr_wb"},  rf_wr_addr_wb,  '0);
        check({tag, " data_wb"},  rf_wr_data_wb,  '0);
        check({tag, " cnt"},      wb_retire_cnt,  '0);
    endtask

    initial begin
        m_mem = '0; m_wb = '0; m_cnt = '0;
        #3;
        zero_outputs("reset");
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // Unmasked 32-bit, vl=3
        step("u32", 1, 1, 5'd5, D1, 4'b0100, 5'd3, 1, '0, 0, 0);
        check("u32 lit en_mem", rf_wr_en_mem, 16'h0FFF);
        check("u32 lit addr_mem", rf_wr_addr_mem, 5'd5);
        idle("u32+2");
        check("u32 lit en_wb", rf_wr_en_wb, 16'h0FFF);
        check("u32 lit cnt", wb_retire_cnt, 32'd1);

        // Masked and unmasked 8-bit
        step("m8", 1, 1, 5'd7, D2, 4'b0001, 5'd16, 0, 16'hA5A5, 0, 0);
        check("m8 lit en_mem", rf_wr_en_mem, 16'hA5A5);
        step("u8", 1, 1, 5'd8, D3, 4'b0001, 5'd16, 1, 16'hA5A5, 0, 0);
        check("u8 lit en_mem", rf_wr_en_mem, 16'hFFFF);
        step("m16", 1, 1, 5'd9, D1, 4'b0110, 5'd5, 0, 16'h0013, 0, 0);

        // vl clamp with 64-bit elements
        step("c5", 1, 1, 5'd10, D2, 4'b1000, 5'd5, 1, '0, 0, 0);
        check("c5 lit en_mem", rf_wr_en_mem, 16'hFFFF);
        step("c1", 1, 1, 5'd11, D3, 4'b1000, 5'd1, 1, '0, 0, 0);
        check("c1 lit en_mem", rf_wr_en_mem, 16'h00FF);
        step("c0", 1, 1, 5'd12, D1, 4'b1000, 5'd0, 1, '0, 0, 0);
        check("c0 lit en_mem", rf_wr_en_mem, 16'h0000);
        step("os0", 1, 1, 5'd13, D2, 4'b0000, 5'd16, 1, '0, 0, 0);
        check("os0 lit en_mem", rf_wr_en_mem, 16'h0000);
        idle("drain1");
        idle("drain2");

        // Stall: A then B held for two stalled cycles
        step("stA", 1, 1, 5'd1, D1, 4'b0001, 5'd16, 1, '0, 0, 0);
        idle("stgap");
        step("stB1", 1, 1, 5'd2, D2, 4'b0010, 5'd4, 1, '0, 0, 1);
        check("st1 lit en_wb", rf_wr_en_wb, 16'h0000);
        step("stB2", 1, 1, 5'd2, D2, 4'b0010, 5'd4, 1, '0, 0, 1);
        step("stB3", 1, 1, 5'd2, D2, 4'b0010, 5'd4, 1, '0, 0, 0);
        check("stB lit en_mem", rf_wr_en_mem, 16'h00FF);
        idle("stB+2");
        check("stB lit en_wb", rf_wr_en_wb, 16'h00FF);
        // Stall and flush together: MEM keeps its contents
        step("stA2", 1, 1, 5'd3, D3, 4'b0001, 5'd16, 1, '0, 0, 0);
        step("stfl", 1, 1, 5'd4, D1, 4'b0001, 5'd16, 1, '0, 1, 1);
        check("stfl lit en_mem", rf_wr_en_mem, 16'hFFFF);
        idle("stfl+1");
        idle("stfl+2");

        // Flush
        step("fl", 1, 1, 5'd6, D2, 4'b0001, 5'd16, 1, '0, 1, 0);
        check("fl lit en_mem", rf_wr_en_mem, 16'h0000);
        idle("fl+2");
        check("fl lit en_wb", rf_wr_en_wb, 16'h0000);
        idle("fl+3");

        // Reset while MEM and WB both hold live enables
        step("rA", 1, 1, 5'd14, D1, 4'b0100, 5'd4, 1, '0, 0, 0);
        step("rB", 1, 1, 5'd15, D2, 4'b0001, 5'd9, 1, '0, 0, 0);
        check("rB lit en_wb", rf_wr_en_wb, 16'hFFFF);
        #2;
        rst_n = 1'b0;
        #1;
        zero_outputs("rst_async");
        @(posedge clk);
        #1;
        zero_outputs("rst_hold");
        rst_n = 1'b1;
        m_mem = '0; m_wb = '0; m_cnt = '0;
        exp_q.delete();
        step("post", 1, 1, 5'd17, D3, 4'b0010, 5'd2, 1, '0, 0, 0);
        check("post lit en_mem", rf_wr_en_mem, 16'h000F);
        check("post lit en_wb", rf_wr_en_wb, 16'h0000);
        idle("post+2");
        check("post lit en_wb2", rf_wr_en_wb, 16'h000F);
        check("post lit cnt", wb_retire_cnt, 32'd1);
        idle("post+3");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
